// File: rtl/uart_frame_packer_pkg.sv
// uart_frame_packer_pkg: FSM state encoding and default frame delimiters.
package uart_frame_packer_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;
    localparam logic [7:0] DEF_HEAD_BYTE = 8'hA5;
    localparam logic [7:0] DEF_TAIL_BYTE = 8'h5A;
endpackage

// File: rtl/uart_frame_packer_sync_edge.sv
// sync_edge: two-flop synchroniser and registered rising-edge detector.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_edge
);
    logic r_meta, r_sync, r_prev;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            o_edge <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            o_edge <= r_sync & ~r_prev;
        end
    end
endmodule

// File: rtl/uart_frame_packer.sv
// uart_frame_packer: snapshots channel data on a sync edge and feeds it to a UART
// byte by byte as HEAD, seq, channel bytes (MSB first), optional XOR checksum, TAIL.
module uart_frame_packer
    import uart_frame_packer_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter int         DATA_W    = 32,
    parameter logic [7:0] HEAD_BYTE = DEF_HEAD_BYTE,
    parameter logic [7:0] TAIL_BYTE = DEF_TAIL_BYTE,
    parameter int         CHK_EN    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sync,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     tx_empty,
    output logic                     ld_tx_data_ctr,
    output logic [7:0]               tx_data_ctr,
    output logic                     tx_enable_ctr,
    output logic                     busy,
    output logic                     overrun,
    output logic [7:0]               drop_cnt
);
    localparam int BPC       = DATA_W / 8;
    localparam int NB        = NUM_CH * BPC;
    localparam int FRAME_LEN = 3 + NB + ((CHK_EN != 0) ? 1 : 0);
    localparam int IW        = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

    state_t                    r_state;
    logic [NUM_CH*DATA_W-1:0]  r_hold;
    logic [7:0]                r_seq;
    logic [IW-1:0]             r_idx;
    logic                      w_edge;
    logic [7:0]                w_frame [FRAME_LEN];
    logic [7:0]                w_chk;

    sync_edge u_sync_edge (
        .clock   (clock),
        .reset   (reset),
        .i_async (sync),
        .o_edge  (w_edge)
    );

    // Whole frame laid out from the snapshot; the FSM just walks r_idx through it.
    always_comb begin
        w_frame[0] = HEAD_BYTE;
        w_frame[1] = r_seq;
        for (int k = 0; k < NB; k++)
            w_frame[k+2] = r_hold[(k/BPC)*DATA_W + DATA_W - 8*(k%BPC) - 1 -: 8];
        w_chk = r_seq;
        for (int k = 0; k < NB; k++)
            w_chk = w_chk ^ w_frame[k+2];
        if (CHK_EN != 0)
            w_frame[FRAME_LEN-2] = w_chk;
        w_frame[FRAME_LEN-1] = TAIL_BYTE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_hold         <= '0;
            r_seq          <= '0;
            r_idx          <= '0;
            ld_tx_data_ctr <= 1'b0;
            tx_data_ctr    <= '0;
            tx_enable_ctr  <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            drop_cnt       <= '0;
        end else begin
            ld_tx_data_ctr <= 1'b0;
            overrun        <= w_edge && r_state != IDLE;
            if (w_edge && r_state != IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            case (r_state)
                IDLE: if (w_edge) begin
                    r_hold        <= ch_data;
                    r_seq         <= r_seq + 8'd1;
                    r_idx         <= '0;
                    r_state       <= LOAD;
                    tx_enable_ctr <= 1'b1;
                    busy          <= 1'b1;
                end
                LOAD: if (tx_empty) begin
                    ld_tx_data_ctr <= 1'b1;
                    tx_data_ctr    <= w_frame[r_idx];
                    r_state        <= WAIT_ACK;
                end
                WAIT_ACK: if (!tx_empty) r_state <= WAIT_DONE;
                WAIT_DONE: if (tx_empty) begin
                    if (r_idx == LAST) begin
                        r_state       <= IDLE;
                        tx_enable_ctr <= 1'b0;
                        busy          <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                        r_state <= LOAD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_packer.sv
// tb_uart_frame_packer: directed and random frames against a byte-list reference model,
// with a UART responder that captures every loaded byte.
module tb_uart_frame_packer;
    typedef logic [7:0] bq_t[$];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sync0 = 1'b0, sync1 = 1'b0;
    logic [127:0] ch0 = '0;
    logic [7:0]   ch1 = '0;
    logic         te0, te1, ld0, ld1, en0, en1, busy0, busy1, ov0, ov1;
    logic [7:0]   d0, d1, dc0, dc1;
    logic         stall0 = 1'b0;
    int           bc0 = 0, bc1 = 0, ld_n0 = 0, ov_n0 = 0;
    bq_t          cap0, cap1, exp_q;
    int           n_assert = 0, n_fail = 0;
    logic [7:0]   seq0 = 0, seq1 = 0;
    logic [127:0] snap;

    always #5 clk = ~clk;

    uart_frame_packer u0 (
        .clock(clk), .reset(rst), .sync(sync0), .ch_data(ch0), .tx_empty(te0),
        .ld_tx_data_ctr(ld0), .tx_data_ctr(d0), .tx_enable_ctr(en0), .busy(busy0),
        .overrun(ov0), .drop_cnt(dc0)
    );

    uart_frame_packer #(.NUM_CH(1), .DATA_W(8), .CHK_EN(0)) u1 (
        .clock(clk), .reset(rst), .sync(sync1), .ch_data(ch1), .tx_empty(te1),
        .ld_tx_data_ctr(ld1), .tx_data_ctr(d1), .tx_enable_ctr(en1), .busy(busy1),
        .overrun(ov1), .drop_cnt(dc1)
    );

    // UART responder: empty drops right after a load and returns ~10 cycles later.
    always @(posedge clk) begin
        if (ld0) begin
            cap0.push_back(d0);
            bc0 <= 11;
            ld_n0 <= ld_n0 + 1;
        end else if (bc0 > 0) bc0 <= bc0 - 1;
        if (ov0) ov_n0 <= ov_n0 + 1;
        if (ld1) begin
            cap1.push_back(d1);
            bc1 <= 11;
        end else if (bc1 > 0) bc1 <= bc1 - 1;
    end
    assign te0 = (bc0 == 0) && !stall0;
    assign te1 = (bc1 == 0);

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic pulse(input int which);
        if (which == 0) sync0 = 1'b1; else sync1 = 1'b1;
        tick(4);
        if (which == 0) sync0 = 1'b0; else sync1 = 1'b0;
        tick(4);
    endtask

    task automatic wait_idle(input int which, input string tag);
        for (int i = 0; i < 6000 && (which == 0 ? busy0 : busy1); i++) tick(1);
        chk({tag, "_idle"}, {31'd0, (which == 0 ? busy0 : busy1)}, 32'd0);
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 3000 && cap0.size() < n; i++) tick(1);
        chk("wait_bytes", {31'd0, cap0.size() >= n}, 32'd1);
    endtask

    // Reference frame from the rules: HEAD, seq, channel bytes MSB first, XOR, TAIL.
    function automatic void build(input logic [127:0] ch, input int nch, input int dw,
                                  input bit chk_en, input logic [7:0] seq);
        logic [7:0] x, b;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq);
        x = seq;
        for (int c = 0; c < nch; c++)
            for (int k = 0; k < dw / 8; k++) begin
                b = 8'((ch >> (c * dw + dw - 8 * (k + 1))) & 128'hFF);
                exp_q.push_back(b);
                x = x ^ b;
            end
        if (chk_en) exp_q.push_back(x);
        exp_q.push_back(8'h5A);
    endfunction

    task automatic cmp(input string tag, input int which);
        bq_t c;
        c = (which == 0) ? cap0 : cap1;
        chk({tag, "_len"}, c.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), (i < c.size()) ? {24'd0, c[i]} : 32'hx, {24'd0, exp_q[i]});
    endtask

    task automatic frame0(input string tag, input bit mid_change);
        snap = ch0;
        seq0 = seq0 + 8'd1;
        cap0.delete();
        pulse(0);
        if (mid_change) begin
            wait_bytes(3);
            ch0 = {$urandom, $urandom, $urandom, $urandom};
        end
        wait_idle(0, tag);
        build(snap, 4, 32, 1'b1, seq0);
        cmp(tag, 0);
    endtask

    initial begin
        int base_ld, base_ov;
        tick(2);
        chk("rst_ld", {31'd0, ld0}, 0);
        chk("rst_data", {24'd0, d0}, 0);
        chk("rst_en", {31'd0, en0}, 0);
        chk("rst_busy", {31'd0, busy0}, 0);
        chk("rst_ov", {31'd0, ov0}, 0);
        chk("rst_drop", {24'd0, dc0}, 0);
        rst = 1'b0;
        tick(3);

        ch0 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        frame0("default", 1'b0);
        chk("hold_data", {24'd0, d0}, 32'h5A);
        chk("idle_en", {31'd0, en0}, 0);

        ch0 = {$urandom, $urandom, $urandom, $urandom};
        snap = ch0;
        seq0 = seq0 + 8'd1;
        cap0.delete();
        base_ov = ov_n0;
        pulse(0);
        wait_bytes(5);
        ch0 = {$urandom, $urandom, $urandom, $urandom};
        pulse(0);
        chk("busy_mid", {31'd0, busy0}, 1);
        wait_idle(0, "overlap");
        build(snap, 4, 32, 1'b1, seq0);
        cmp("overlap", 0);
        chk("ov_pulses", ov_n0 - base_ov, 1);
        chk("drop_one", {24'd0, dc0}, 1);

        for (int r = 0; r < 3; r++) begin
            ch0 = {$urandom, $urandom, $urandom, $urandom};
            frame0($sformatf("rand%0d", r), 1'b1);
        end

        stall0 = 1'b1;
        ch0 = {$urandom, $urandom, $urandom, $urandom};
        snap = ch0;
        seq0 = seq0 + 8'd1;
        cap0.delete();
        base_ld = ld_n0;
        pulse(0);
        tick(50);
        chk("stall_no_ld", ld_n0 - base_ld, 0);
        chk("stall_busy", {31'd0, busy0}, 1);
        stall0 = 1'b0;
        tick(12);
        chk("stall_one_ld", ld_n0 - base_ld, 1);
        wait_idle(0, "stall");
        build(snap, 4, 32, 1'b1, seq0);
        cmp("stall", 0);

        stall0 = 1'b1;
        pulse(0);
        for (int i = 0; i < 300; i++) pulse(0);
        chk("drop_sat", {24'd0, dc0}, 255);
        chk("sat_busy", {31'd0, busy0}, 1);
        rst = 1'b1;
        #1;
        chk("arst_drop", {24'd0, dc0}, 0);
        chk("arst_busy", {31'd0, busy0}, 0);
        chk("arst_en", {31'd0, en0}, 0);
        stall0 = 1'b0;
        tick(2);
        rst = 1'b0;
        seq0 = 0;
        tick(20);

        ch0 = {$urandom, $urandom, $urandom, $urandom};
        cap0.delete();
        pulse(0);
        wait_bytes(8);
        rst = 1'b1;
        #1;
        chk("mid_rst_ld", {31'd0, ld0}, 0);
        chk("mid_rst_data", {24'd0, d0}, 0);
        chk("mid_rst_en", {31'd0, en0}, 0);
        chk("mid_rst_busy", {31'd0, busy0}, 0);
        tick(2);
        rst = 1'b0;
        base_ld = ld_n0;
        tick(100);
        chk("post_rst_no_ld", ld_n0 - base_ld, 0);
        ch0 = {$urandom, $urandom, $urandom, $urandom};
        frame0("after_rst", 1'b1);

        for (int r = 0; r < 3; r++) begin
            ch1 = (r == 0) ? 8'hC3 : 8'($urandom);
            seq1 = seq1 + 8'd1;
            cap1.delete();
            snap = {120'd0, ch1};
            pulse(1);
            wait_idle(1, $sformatf("small%0d", r));
            build(snap, 1, 8, 1'b0, seq1);
            cmp($sformatf("small%0d", r), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
